// File: rtl/tdc_tap_encoder.sv
// Capture stage behind a unit_buffer delay chain. It synchronizes the chain taps,
// converts each thermometer sample to a tap count, and averages 2^AVG_LOG2 samples.
module tdc_tap_encoder #(
  parameter int TAPS     = 16,
  parameter int AVG_LOG2 = 2,
  parameter int OUT_W    = $clog2(TAPS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAPS-1:0]  taps,
  input  logic             start,
  output logic             busy,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [OUT_W-1:0] code,
  output logic             overflow,
  output logic             bubble_err,
  output logic [1:0]       dbg_state
);

  localparam int ACC_W = OUT_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int N     = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [TAPS-1:0]   s1, s2;
  logic [OUT_W-1:0]  cnt;
  logic              bub, ovf, found;
  logic [ACC_W-1:0]  acc, acc_sum;
  logic [CNT_W-1:0]  nsamp;
  logic              ovf_acc, bub_acc;
  logic              last_sample;

  // Tap count is the index of the lowest 0; any 1 above that 0 is a bubble.
  always_comb begin
    cnt   = OUT_W'(TAPS);
    found = 1'b0;
    bub   = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (!found) begin
        if (!s2[i]) begin
          cnt   = OUT_W'(i);
          found = 1'b1;
        end
      end else if (s2[i]) begin
        bub = 1'b1;
      end
    end
  end

  assign ovf         = &s2;
  assign acc_sum     = acc + ACC_W'(cnt);
  assign last_sample = (nsamp == CNT_W'(N-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake: the result transfers on any rising edge where code_valid and
  // code_ready are both high; code_valid never drops until that transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = ACCUM;
      ACCUM:   if (last_sample) state_nxt = HOLD;
      HOLD:    if (code_ready)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      acc        <= '0;
      nsamp      <= '0;
      ovf_acc    <= 1'b0;
      bub_acc    <= 1'b0;
      code       <= '0;
      overflow   <= 1'b0;
      bubble_err <= 1'b0;
    end else begin
      s1 <= taps;
      s2 <= s1;
      case (state)
        IDLE: begin
          acc     <= '0;
          nsamp   <= '0;
          ovf_acc <= 1'b0;
          bub_acc <= 1'b0;
          // Previous result stays visible until a new measurement begins.
          if (start) begin
            code       <= '0;
            overflow   <= 1'b0;
            bubble_err <= 1'b0;
          end
        end
        ACCUM: begin
          acc     <= acc_sum;
          nsamp   <= nsamp + CNT_W'(1);
          ovf_acc <= ovf_acc | ovf;
          bub_acc <= bub_acc | bub;
          if (last_sample) begin
            code       <= OUT_W'(acc_sum >> AVG_LOG2);
            overflow   <= ovf_acc | ovf;
            bubble_err <= bub_acc | bub;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign code_valid = (state == HOLD);
  assign dbg_state  = state;

endmodule

// File: doc/tdc_tap_encoder.md
# tdc_tap_encoder

Time-to-digital capture stage sitting directly downstream of a chain of `unit_buffer` delay elements. On request, it samples the buffer-chain tap outputs on `clk` and synchronizes them. It converts each thermometer sample to a binary tap count, averages a fixed number of samples, and offers the result over a valid/ready handshake. It also flags chain overflow and thermometer bubbles.

## Interface
- `TAPS`, 16, number of buffer-chain taps sampled; `taps[0]` is the tap nearest the chain input.
- `AVG_LOG2`, 2, log2 of samples averaged per measurement (N = 2^AVG_LOG2, N ≥ 1).
- `OUT_W`, $clog2(TAPS+1), width of `code` (5 for defaults).

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `taps`  in  TAPS  raw tap outputs of the `unit_buffer` chain, asynchronous to `clk`.
- `start`  in  1  single-cycle measurement request; honoured only in IDLE.
- `busy`  out  1  high in ACCUM and HOLD.
- `code_valid`  out  1  high in HOLD; `code` and flags are valid.
- `code_ready`  in  1  consumer accepts the result when high together with `code_valid`.
- `code`  out  OUT_W  averaged tap count, range 0..TAPS.
- `overflow`  out  1  at least one sample in the measurement had all taps high.
- `bubble_err`  out  1  at least one sample had a 1 above its first 0.

## Operation
- Synchronizer:
  - Two flop stages `s1 <= taps`, `s2 <= s1` run every cycle regardless of state.
  - Only `s2` is used downstream.
- Per-sample encoding (combinational on `s2`):
  - `cnt` = index of the lowest 0 bit, or TAPS if all ones.
  - Bits above that 0 are ignored for `cnt`.
  - `bub` = 1 if any bit above the first 0 is 1.
  - `ovf` = (`s2` all ones).
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE:
    - `start` = 1 → ACCUM.
    - Clear the accumulator, sample counter, and sticky flags.
  - ACCUM:
    - Each cycle: `acc += cnt`, OR `bub` into `bubble_err`, OR `ovf` into `overflow`, increment the sample counter.
    - After the N-th accumulation → HOLD.
    - `start` is ignored.
  - HOLD:
    - Drive `code = acc >> AVG_LOG2` (truncating) and `code_valid` = 1.
    - `code_valid && code_ready` → IDLE.
    - Otherwise remain in HOLD with all outputs stable.
    - `start` is ignored.
- Arithmetic:
  - `acc` width is OUT_W+AVG_LOG2, so N·TAPS never wraps.
  - The shifted result always fits in OUT_W.
  - The sample counter width is max(AVG_LOG2,1); it wraps to 0 on entry to HOLD.
- `code`, `overflow` and `bubble_err` are registered.
  - They are 0 outside HOLD, except that they retain the last values until the first ACCUM cycle clears them.
  - Implement them as cleared on IDLE→ACCUM transition and zero in IDLE after reset.

## Timing
- Reset (`rst` = 1 at an edge):
  - Next cycle: state IDLE; `busy`, `code_valid`, `overflow`, `bubble_err` = 0; `code` = 0; accumulator and counter = 0.
  - Synchronizer flops = 0.
- Reset overrides everything, including a pending handshake or mid-ACCUM measurement; a partially accumulated result is discarded.
- `start` sampled high in IDLE at edge c:
  - ACCUM during cycles c+1 .. c+N.
  - Accumulates `s2` in those cycles, i.e. `taps` as presented in cycles c-1 .. c+N-2.
- HOLD from cycle c+N+1: `code_valid` rises N+1 cycles after `start` (5 cycles for defaults).
- A handshake at edge h returns the block to IDLE at h+1 with `code_valid` = 0.
  - The earliest accepted new `start` is at edge h+1.
  - Minimum measurement period is N+2 cycles.
- `start` coincident with a HOLD handshake is dropped.
- `taps` must be stable for ≥ 2 cycles before `start` for a deterministic single-valued result.

## Test plan
- Basic count (static `taps` = 16'h00FF for ≥3 cycles, then `start`):
  - `code_valid` rises exactly 5 cycles later.
  - `code` = 8; `overflow` = 0; `bubble_err` = 0.
- Extremes:
  - `taps` = 16'h0000 → `code` = 0, flags 0.
  - `taps` = 16'hFFFF → `code` = 16, `overflow` = 1.
- Bubble (`taps` = 16'h00F7):
  - `code` = 3, `bubble_err` = 1.
- Averaging (`s2` sequence 16'h000F, 16'h003F, 16'h000F, 16'h003F over the 4 ACCUM cycles):
  - Sum is 20; `code` = 5.
  - An odd sum (e.g. 4,4,4,5) truncates to `code` = 4.
- Backpressure:
  - Hold `code_ready` = 0 for 10 cycles in HOLD while pulsing `start` and changing `taps`.
  - `code` and flags remain stable; no new measurement starts.
  - `code_ready` = 1 → `code_valid` = 0 next cycle.
- Reset mid-operation:
  - Assert `rst` in the 2nd ACCUM cycle → next cycle `busy` = 0, `code` = 0, flags 0.
  - A fresh `start` then yields a correct result after 5 cycles.
